// File: rtl/brick_wall_ctrl.sv
// Brick wall, score/lives bookkeeping and serve/play/over/won sequencing for breakout.
// Hits, pulses and state update one cycle after a tick; pixel colour is one cycle behind x/y.
// No backpressure: tick paces the game, launch is a level request, outputs are always valid.
module brick_wall_ctrl #(
   parameter int ROWS    = 5,
   parameter int COLS    = 10,
   parameter int BRICK_W = 60,
   parameter int BRICK_H = 40,
   parameter int X0      = 20,
   parameter int Y0      = 40,
   parameter int LIVES   = 3,
   parameter int FLOOR_Y = 470,
   parameter int SCORE_W = $clog2(ROWS*COLS+1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               launch,
   input  logic [9:0]         ball_x,
   input  logic [8:0]         ball_y,
   input  logic [9:0]         x,
   input  logic [8:0]         y,
   input  logic               paddle_pix,
   input  logic               ball_pix,
   output logic               x_hit,
   output logic               y_hit,
   output logic [SCORE_W-1:0] score,
   output logic [2:0]         lives,
   output logic               playing,
   output logic               game_over,
   output logic               game_won,
   output logic [7:0]         r,
   output logic [7:0]         g,
   output logic [7:0]         b
);

   localparam int NB = ROWS*COLS;

   typedef enum logic [1:0] {SERVE, PLAY, OVER, WON} state_t;

   state_t        state, state_nxt;
   logic [NB-1:0] alive;
   logic [9:0]    prev_x;
   logic [8:0]    prev_y;

   logic          hit_vld;
   logic [NB-1:0] hit_mask;
   logic          prev_in_y;
   logic          last_hit;
   logic          floor_hit;
   logic          play_tick;
   logic          pix_brick;
   logic [23:0]   brick_rgb;
   logic [23:0]   pix_rgb;

   // prev_x is tracked alongside prev_y for a future side-deflection rule; nothing consumes it yet
   logic          unused_prev_x;
   assign unused_prev_x = ^prev_x;

   // Strict interior test: pixels on a brick edge belong to no brick
   function automatic logic in_span(input int p, input int lo, input int w);
      return (p > lo) && (p < lo + w);
   endfunction

   function automatic logic [23:0] row_colour(input int row);
      case (row % 4)
         0:       return 24'hFF0000;
         1:       return 24'h0000FF;
         2:       return 24'h00FF00;
         default: return 24'hFFFF00;
      endcase
   endfunction

   assign play_tick = (state == PLAY) && tick;
   assign floor_hit = int'(ball_y) >= FLOOR_Y;
   assign last_hit  = hit_vld && ((alive & ~hit_mask) == '0);
   assign playing   = (state == PLAY);
   assign game_over = (state == OVER);
   assign game_won  = (state == WON);

   // Find the first alive brick under the ball (lowest row, then lowest column)
   always_comb begin
      hit_vld   = 1'b0;
      hit_mask  = '0;
      prev_in_y = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLS; j++) begin
            if (!hit_vld && alive[i*COLS+j] &&
                in_span(int'(ball_x), X0 + j*BRICK_W, BRICK_W) &&
                in_span(int'(ball_y), Y0 + i*BRICK_H, BRICK_H)) begin
               hit_vld              = 1'b1;
               hit_mask[i*COLS+j]   = 1'b1;
               prev_in_y            = in_span(int'(prev_y), Y0 + i*BRICK_H, BRICK_H);
            end
         end
      end
   end

   // Game state register
   always_ff @(posedge clk) begin
      if (reset) state <= SERVE;
      else       state <= state_nxt;
   end

   // Next state: clearing the wall wins even if the ball also reached the floor
   always_comb begin
      state_nxt = state;
      case (state)
         SERVE: if (launch) state_nxt = PLAY;
         PLAY: begin
            if (tick) begin
               if (last_hit)            state_nxt = WON;
               else if (floor_hit)      state_nxt = (lives == 3'd1) ? OVER : SERVE;
            end
         end
         OVER, WON: if (launch) state_nxt = SERVE;
         default: state_nxt = SERVE;
      endcase
   end

   // Wall, score, lives and deflection pulses; restart refills everything from OVER/WON
   always_ff @(posedge clk) begin
      if (reset) begin
         alive  <= {NB{1'b1}};
         score  <= '0;
         lives  <= 3'(LIVES);
         prev_x <= '0;
         prev_y <= '0;
         x_hit  <= 1'b0;
         y_hit  <= 1'b0;
      end else begin
         x_hit <= 1'b0;
         y_hit <= 1'b0;
         if (play_tick) begin
            prev_x <= ball_x;
            prev_y <= ball_y;
            if (hit_vld) begin
               alive <= alive & ~hit_mask;
               score <= score + SCORE_W'(1);
               // Ball came from above/below the brick -> vertical bounce, else sideways
               y_hit <= !prev_in_y;
               x_hit <= prev_in_y;
            end
            if (floor_hit && !last_hit) lives <= lives - 3'd1;
         end else if ((state == OVER || state == WON) && launch) begin
            alive <= {NB{1'b1}};
            score <= '0;
            lives <= 3'(LIVES);
         end
      end
   end

   // Colour of the current pixel before the end-of-game tint
   always_comb begin
      pix_brick = 1'b0;
      brick_rgb = 24'h000000;
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLS; j++) begin
            if (alive[i*COLS+j] &&
                in_span(int'(x), X0 + j*BRICK_W, BRICK_W) &&
                in_span(int'(y), Y0 + i*BRICK_H, BRICK_H)) begin
               pix_brick = 1'b1;
               brick_rgb = row_colour(i);
            end
         end
      end
      if (pix_brick)
         pix_rgb = brick_rgb;
      else if ((paddle_pix || ball_pix) && state != OVER && state != WON)
         pix_rgb = 24'hFFFFFF;
      else
         pix_rgb = 24'h000000;
      if (state == OVER) pix_rgb[23:16] = 8'hFF;
      if (state == WON)  pix_rgb[15:8]  = 8'hFF;
   end

   // Registered VGA colour
   always_ff @(posedge clk) begin
      if (reset) begin
         r <= 8'h00;
         g <= 8'h00;
         b <= 8'h00;
      end else begin
         r <= pix_rgb[23:16];
         g <= pix_rgb[15:8];
         b <= pix_rgb[7:0];
      end
   end

endmodule

// File: tb/tb_brick_wall_ctrl.sv
// Directed scoreboard bench for brick_wall_ctrl: default wall plus a 1x2 wall near the floor.
// Each step drives inputs on the falling edge and checks outputs just after the rising edge.
// No backpressure involved; every step advances exactly one clock.
module tb_brick_wall_ctrl;

   localparam int S = 0, P = 1, O = 2, W = 4, H = 255;

   logic       clk = 1'b0;
   logic       reset = 1'b1, tick = 1'b0, launch = 1'b0;
   logic [9:0] ball_x = '0, x = '0;
   logic [8:0] ball_y = '0, y = '0;
   logic       paddle_pix = 1'b0, ball_pix = 1'b0;

   logic       x_hit, y_hit, playing, game_over, game_won;
   logic [5:0] score;
   logic [2:0] lives;
   logic [7:0] r, g, b;

   logic       x_hit_s, y_hit_s, playing_s, game_over_s, game_won_s;
   logic [1:0] score_s;
   logic [2:0] lives_s;
   logic [7:0] r_s, g_s, b_s;

   always #5 clk = ~clk;

   brick_wall_ctrl u_dut (
      .clk(clk), .reset(reset), .tick(tick), .launch(launch),
      .ball_x(ball_x), .ball_y(ball_y), .x(x), .y(y),
      .paddle_pix(paddle_pix), .ball_pix(ball_pix),
      .x_hit(x_hit), .y_hit(y_hit), .score(score), .lives(lives),
      .playing(playing), .game_over(game_over), .game_won(game_won),
      .r(r), .g(g), .b(b)
   );

   brick_wall_ctrl #(.ROWS(1), .COLS(2), .Y0(440)) u_dut_s (
      .clk(clk), .reset(reset), .tick(tick), .launch(launch),
      .ball_x(ball_x), .ball_y(ball_y), .x(x), .y(y),
      .paddle_pix(paddle_pix), .ball_pix(ball_pix),
      .x_hit(x_hit_s), .y_hit(y_hit_s), .score(score_s), .lives(lives_s),
      .playing(playing_s), .game_over(game_over_s), .game_won(game_won_s),
      .r(r_s), .g(g_s), .b(b_s)
   );

   typedef struct {
      string tag;
      int    which;
      int    xh, yh, sc, lv, st, r, g, b;
   } exp_t;

   exp_t sb_q[$];
   int   n_run  = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input bit rs, input bit la, input bit tk,
                       input int bx, input int by, input int px, input int py,
                       input bit pp, input bit bp, input int which,
                       input int exh, input int eyh, input int esc, input int elv,
                       input int est, input int er, input int eg, input int eb);
      exp_t        e;
      logic [31:0] o_xh, o_yh, o_sc, o_lv, o_st, o_r, o_g, o_b;
      @(negedge clk);
      reset      = rs;
      launch     = la;
      tick       = tk;
      ball_x     = 10'(bx);
      ball_y     = 9'(by);
      x          = 10'(px);
      y          = 9'(py);
      paddle_pix = pp;
      ball_pix   = bp;
      e.tag = tag; e.which = which;
      e.xh = exh; e.yh = eyh; e.sc = esc; e.lv = elv; e.st = est;
      e.r = er; e.g = eg; e.b = eb;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      if (e.which == 0) begin
         o_xh = 32'(x_hit);   o_yh = 32'(y_hit);   o_sc = 32'(score); o_lv = 32'(lives);
         o_st = 32'({game_won, game_over, playing});
         o_r  = 32'(r);       o_g  = 32'(g);       o_b  = 32'(b);
      end else begin
         o_xh = 32'(x_hit_s); o_yh = 32'(y_hit_s); o_sc = 32'(score_s); o_lv = 32'(lives_s);
         o_st = 32'({game_won_s, game_over_s, playing_s});
         o_r  = 32'(r_s);     o_g  = 32'(g_s);     o_b  = 32'(b_s);
      end
      chk({e.tag, ".x_hit"}, o_xh, e.xh);
      chk({e.tag, ".y_hit"}, o_yh, e.yh);
      chk({e.tag, ".score"}, o_sc, e.sc);
      chk({e.tag, ".lives"}, o_lv, e.lv);
      chk({e.tag, ".state"}, o_st, e.st);
      chk({e.tag, ".r"},     o_r,  e.r);
      chk({e.tag, ".g"},     o_g,  e.g);
      chk({e.tag, ".b"},     o_b,  e.b);
   endtask

   initial begin
      //    tag            rs la tk  bx   by   px   py  pp bp dut xh yh sc lv st  r  g  b
      // Reset, serve, vertical hit and pixel colours
      step("rst",          1, 0, 0,   0,   0,   0,   0, 0, 0, 0, 0, 0, 0, 3, S, 0, 0, 0);
      step("serve_go",     0, 1, 0,   0,   0,   0,   0, 0, 0, 0, 0, 0, 0, 3, P, 0, 0, 0);
      step("prev_y100",    0, 0, 1,   0, 100,  50,  60, 0, 0, 0, 0, 0, 0, 3, P, H, 0, 0);
      step("hit00_y",      0, 0, 1,  50,  60,  50,  60, 0, 0, 0, 0, 1, 1, 3, P, H, 0, 0);
      step("dead_pix",     0, 0, 0,  50,  60,  50,  60, 0, 0, 0, 0, 0, 1, 3, P, 0, 0, 0);
      step("row1_blue",    0, 0, 0,   0,   0,  50, 100, 0, 0, 0, 0, 0, 1, 3, P, 0, 0, H);
      step("row2_green",   0, 0, 0,   0,   0,  50, 140, 0, 0, 0, 0, 0, 1, 3, P, 0, H, 0);
      step("row3_yellow",  0, 0, 0,   0,   0,  50, 180, 0, 0, 0, 0, 0, 1, 3, P, H, H, 0);
      step("row4_red",     0, 0, 0,   0,   0,  50, 220, 0, 0, 0, 0, 0, 1, 3, P, H, 0, 0);
      step("paddle_white", 0, 0, 0,   0,   0,   5,   5, 1, 0, 0, 0, 0, 1, 3, P, H, H, H);
      step("ball_white",   0, 0, 0,   0,   0,   5,   5, 0, 1, 0, 0, 0, 1, 3, P, H, H, H);
      step("edge_pix",     0, 0, 0,   0,   0,  80, 100, 0, 0, 0, 0, 0, 1, 3, P, 0, 0, 0);
      // Sideways hit, dead brick, edges
      step("rst2",         1, 0, 0,   0,   0,   0,   0, 0, 0, 0, 0, 0, 0, 3, S, 0, 0, 0);
      step("serve_go2",    0, 1, 0,   0,   0,   0,   0, 0, 0, 0, 0, 0, 0, 3, P, 0, 0, 0);
      step("prev_in",      0, 0, 1,  15,  60,   0,   0, 0, 0, 0, 0, 0, 0, 3, P, 0, 0, 0);
      step("hit00_x",      0, 0, 1,  25,  60,   0,   0, 0, 0, 0, 1, 0, 1, 3, P, 0, 0, 0);
      step("rehit_dead",   0, 0, 1,  25,  60,   0,   0, 0, 0, 0, 0, 0, 1, 3, P, 0, 0, 0);
      step("edge_x80",     0, 0, 1,  80,  60,   0,   0, 0, 0, 0, 0, 0, 1, 3, P, 0, 0, 0);
      step("edge_x140",    0, 0, 1, 140,  60,   0,   0, 0, 0, 0, 0, 0, 1, 3, P, 0, 0, 0);
      step("edge_y80",     0, 0, 1,  50,  80,   0,   0, 0, 0, 0, 0, 0, 1, 3, P, 0, 0, 0);
      // Losing all lives
      step("loss1",        0, 0, 1, 300, 470,   0,   0, 0, 0, 0, 0, 0, 1, 2, S, 0, 0, 0);
      step("serve_l1",     0, 1, 0,   0,   0,   0,   0, 0, 0, 0, 0, 0, 1, 2, P, 0, 0, 0);
      step("loss2",        0, 0, 1, 300, 470,   0,   0, 0, 0, 0, 0, 0, 1, 1, S, 0, 0, 0);
      step("serve_l2",     0, 1, 0,   0,   0,   0,   0, 0, 0, 0, 0, 0, 1, 1, P, 0, 0, 0);
      step("loss3_over",   0, 0, 1, 300, 470,   0,   0, 0, 0, 0, 0, 0, 1, 0, O, 0, 0, 0);
      step("over_pix",     0, 0, 0,   0,   0,   0,   0, 0, 0, 0, 0, 0, 1, 0, O, H, 0, 0);
      step("over_brick",   0, 0, 0,   0,   0, 100, 100, 0, 0, 0, 0, 0, 1, 0, O, H, 0, H);
      step("over_paddle",  0, 0, 0,   0,   0,   5,   5, 1, 0, 0, 0, 0, 1, 0, O, H, 0, 0);
      step("over_tick",    0, 0, 1,  50, 100,   0,   0, 0, 0, 0, 0, 0, 1, 0, O, H, 0, 0);
      step("over_restart", 0, 1, 0,   0,   0,   0,   0, 0, 0, 0, 0, 0, 0, 3, S, H, 0, 0);
      step("restart_play", 0, 1, 0,   0,   0,  50,  60, 0, 0, 0, 0, 0, 0, 3, P, H, 0, 0);
      // Build score 3 / lives 1, then reset mid-play
      step("t6_hit1",      0, 0, 1,  50,  60,   0,   0, 0, 0, 0, 0, 1, 1, 3, P, 0, 0, 0);
      step("t6_hit2",      0, 0, 1, 110,  60,   0,   0, 0, 0, 0, 1, 0, 2, 3, P, 0, 0, 0);
      step("t6_hit3",      0, 0, 1, 170,  60,   0,   0, 0, 0, 0, 1, 0, 3, 3, P, 0, 0, 0);
      step("t6_loss1",     0, 0, 1, 300, 470,   0,   0, 0, 0, 0, 0, 0, 3, 2, S, 0, 0, 0);
      step("t6_serve1",    0, 1, 0,   0,   0,   0,   0, 0, 0, 0, 0, 0, 3, 2, P, 0, 0, 0);
      step("t6_loss2",     0, 0, 1, 300, 470,   0,   0, 0, 0, 0, 0, 0, 3, 1, S, 0, 0, 0);
      step("t6_serve2",    0, 1, 0,   0,   0,   0,   0, 0, 0, 0, 0, 0, 3, 1, P, 0, 0, 0);
      step("mid_reset",    1, 1, 1, 230,  60,   5,   5, 1, 0, 0, 0, 0, 0, 3, S, 0, 0, 0);
      step("post_reset",   0, 0, 1, 230,  60,  50,  60, 0, 0, 0, 0, 0, 0, 3, S, H, 0, 0);
      // 1x2 wall sitting on the floor line: win beats simultaneous loss
      step("s_rst",        1, 0, 0,   0,   0,   0,   0, 0, 0, 1, 0, 0, 0, 3, S, 0, 0, 0);
      step("s_go",         0, 1, 0,   0,   0,   0,   0, 0, 0, 1, 0, 0, 0, 3, P, 0, 0, 0);
      step("s_hit0",       0, 0, 1,  50, 460,   0,   0, 0, 0, 1, 0, 1, 1, 3, P, 0, 0, 0);
      step("s_win_floor",  0, 0, 1, 110, 470,   0,   0, 0, 0, 1, 1, 0, 2, 3, W, 0, 0, 0);
      step("s_won_pix",    0, 0, 0,   0,   0,   0,   0, 0, 0, 1, 0, 0, 2, 3, W, 0, H, 0);
      step("s_won_paddle", 0, 0, 0,   0,   0,   5,   5, 1, 0, 1, 0, 0, 2, 3, W, 0, H, 0);
      step("s_won_tick",   0, 0, 1, 110, 470,   0,   0, 0, 0, 1, 0, 0, 2, 3, W, 0, H, 0);
      step("s_restart",    0, 1, 0,   0,   0,   0,   0, 0, 0, 1, 0, 0, 0, 3, S, 0, H, 0);
      step("s_restart_pl", 0, 1, 0,   0,   0,  50, 460, 0, 0, 1, 0, 0, 0, 3, P, H, 0, 0);
      step("s_rehit_x",    0, 0, 1,  50, 460,   0,   0, 0, 0, 1, 1, 0, 1, 3, P, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/brick_wall_ctrl.md
Name: brick_wall_ctrl

Overview:
Parametrised brick-wall and game-state controller for the breakout game. It generalises the fixed 5x10 wall to ROWS x COLS bricks and adds registered brick state, a wide score counter, a lives counter and a serve/play/over/won state machine. It sits between ball_movement/paddle_movement (ball position in, deflection pulses out) and the VGA driver (registered r/g/b out).

Parameters:
ROWS, 5, brick rows (1..8)
COLS, 10, brick columns (1..16)
BRICK_W, 60, brick width in pixels
BRICK_H, 40, brick height in pixels
X0, 20, left edge of column 0
Y0, 40, top edge of row 0
LIVES, 3, lives at start of game (1..7)
FLOOR_Y, 470, ball_y at or above this value means the ball is lost
SCORE_W, $clog2(ROWS*COLS+1), score width

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
tick  in  1  one-cycle game-update strobe (one per frame)
launch  in  1  serve / restart request, level
ball_x  in  10  ball centre x
ball_y  in  9  ball centre y
x  in  10  VGA pixel x
y  in  9  VGA pixel y
paddle_pix  in  1  paddle covers current pixel
ball_pix  in  1  ball covers current pixel
x_hit  out  1  one-cycle pulse: reverse ball x direction
y_hit  out  1  one-cycle pulse: reverse ball y direction
score  out  SCORE_W  bricks destroyed this game
lives  out  3  remaining lives
playing  out  1  state == PLAY
game_over  out  1  state == OVER
game_won  out  1  state == WON
r, g, b  out  8 each  registered pixel colour

Behaviour:
- Geometry: brick (i,j) occupies X0+j*BRICK_W < px < X0+(j+1)*BRICK_W and Y0+i*BRICK_H < py < Y0+(i+1)*BRICK_H. Comparisons are strict, so edge pixels belong to no brick.
- State: alive[ROWS*COLS] register, prev_x/prev_y registers, score, lives, FSM {SERVE, PLAY, OVER, WON}.
- Reset: alive all 1s, score 0, lives=LIVES, state SERVE, prev_x/prev_y 0, x_hit=y_hit=0, r=g=b=0.
- SERVE: launch=1 -> PLAY on the next cycle.
- PLAY, on a cycle with tick=1:
  - Hit: the first alive brick containing (ball_x,ball_y) is hit. Priority is lowest row index, then lowest column. At most one brick per tick.
  - On a hit, next cycle: alive bit cleared, score+1, and exactly one of these pulses for one cycle:
    - y_hit if prev_y was outside the brick's y span;
    - otherwise x_hit.
  - prev_x/prev_y <= ball_x/ball_y on every PLAY tick.
  - Loss: ball_y >= FLOOR_Y (checked on the same tick). If lives==1 -> lives 0, state OVER; else lives-1, state SERVE.
  - Win: a hit that clears the last alive brick -> WON. Win takes priority over a simultaneous loss; lives are unchanged in that case.
  - launch is ignored in PLAY.
- tick outside PLAY: no hits, no pulses, score and lives frozen.
- OVER or WON: launch=1 -> next cycle alive all 1s, score 0, lives=LIVES, state SERVE. launch is level-sensitive, so SERVE->PLAY follows once launch is still high.
- Score never wraps: the maximum is ROWS*COLS, reached only on WON.
- Pixel path (one-cycle latency from x/y/paddle_pix/ball_pix):
  - alive brick colour from row index mod 4: 0 red (FF,00,00), 1 blue (00,00,FF), 2 green (00,FF,00), 3 yellow (FF,FF,00);
  - paddle_pix or ball_pix -> white, except in OVER/WON;
  - OVER -> r forced FF on every pixel;
  - WON -> g forced FF on every pixel;
  - otherwise black.
- reset asserted mid-game overrides everything in that cycle; outputs return to reset values on the next edge.

Test Plan:
1. Defaults, reset, launch=1 for 1 cycle -> playing=1 one cycle later. tick with ball (50,60), which is inside brick (0,0), prev_y=100 -> next cycle y_hit=1, x_hit=0, score=1. The pixel at (50,60) then reads black.
2. prev=(15,60), tick with ball (25,60) -> x_hit=1, y_hit=0, score=1. A repeat tick at (25,60) gives no pulse and score stays 1 (brick dead).
3. Ball (80,60) or (50,80), on brick edges -> no hit, score unchanged.
4. Ball_y=470 on tick with lives=3 -> lives=2, state SERVE. Repeat twice with launch -> lives=0, game_over=1, and every pixel has r=FF.
5. ROWS=1, COLS=2: clear brick 0, then hit brick 1 on the same tick as ball_y>=FLOOR_Y -> game_won=1, lives unchanged, score=2, every pixel has g=FF. launch -> score=0, alive all 1s, state SERVE.
6. Assert reset mid-PLAY with score=3 and lives=1 -> next cycle score=0, lives=LIVES, state SERVE, r=g=b=0.
